// File: rtl/alu_pkg.sv
// Shared types and constants for the two-requester ALU arbiter.
// Pulled into the interface, the RTL modules and the bench with import alu_pkg::*.
package alu_pkg;

  localparam int NUM_REQ = 2;
  localparam int DATA_W  = 32;

  typedef enum logic [1:0] {
    ADD = 2'd0,
    SUB = 2'd1,
    MUL = 2'd2,
    DIV = 2'd3
  } opcode_t;

  // Operand-B source selector seen by the arithmetic unit.
  localparam logic [1:0] MOVI_REG_B = 2'd0;
  localparam logic [1:0] MOVI_MEM   = 2'd1;
  localparam logic [1:0] MOVI_IMM   = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } arb_state_t;

  function automatic logic [NUM_REQ-1:0] onehot_req(input logic idx);
    return idx ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/alu_arbiter_if.sv
// Bus between the requesters/arithmetic unit (master side) and the arbiter (slave side).
interface alu_arbiter_if;
  import alu_pkg::*;

  // Handshake rule for both req_* and rsp_*: a transfer happens on the rising edge
  // where valid and ready are both 1. A raised valid, and the payload that goes with
  // it, is held by its source until that transfer.
  logic [NUM_REQ-1:0]             req_valid;
  logic [NUM_REQ-1:0]             req_ready;
  logic [NUM_REQ-1:0][1:0]        req_op_code;
  logic [NUM_REQ-1:0][1:0]        req_movi;
  logic [NUM_REQ-1:0][DATA_W-1:0] req_reg_a;
  logic [NUM_REQ-1:0][DATA_W-1:0] req_reg_b;
  logic [NUM_REQ-1:0][DATA_W-1:0] req_mem;
  logic [NUM_REQ-1:0][DATA_W-1:0] req_imm;

  logic [NUM_REQ-1:0]             rsp_valid;
  logic [NUM_REQ-1:0]             rsp_ready;
  logic [DATA_W-1:0]              rsp_data;
  logic                           rsp_err;

  logic                           au_act;
  logic [1:0]                     au_op_code;
  logic [1:0]                     au_movi;
  logic [DATA_W-1:0]              au_reg_a;
  logic [DATA_W-1:0]              au_reg_b;
  logic [DATA_W-1:0]              au_mem;
  logic [DATA_W-1:0]              au_imm;
  logic [DATA_W-1:0]              au_data;
  logic                           au_data_valid;
  logic                           au_rst;

  modport master (
    output req_valid, req_op_code, req_movi, req_reg_a, req_reg_b, req_mem, req_imm,
    output rsp_ready, au_data, au_data_valid,
    input  req_ready, rsp_valid, rsp_data, rsp_err,
    input  au_act, au_op_code, au_movi, au_reg_a, au_reg_b, au_mem, au_imm, au_rst
  );

  modport slave (
    input  req_valid, req_op_code, req_movi, req_reg_a, req_reg_b, req_mem, req_imm,
    input  rsp_ready, au_data, au_data_valid,
    output req_ready, rsp_valid, rsp_data, rsp_err,
    output au_act, au_op_code, au_movi, au_reg_a, au_reg_b, au_mem, au_imm, au_rst
  );

endinterface

// File: rtl/alu_arbiter_rr_arbiter2.sv
// Two-way round-robin grant: on a tie, the requester not granted last time wins.
module rr_arbiter2 (
  input  logic [1:0] req,
  input  logic       last,
  output logic       gnt_valid,
  output logic       gnt_idx
);

  always_comb begin
    gnt_valid = |req;
    gnt_idx   = 1'b0;
    case (req)
      2'b01:   gnt_idx = 1'b0;
      2'b10:   gnt_idx = 1'b1;
      2'b11:   gnt_idx = ~last;
      default: gnt_idx = 1'b0;
    endcase
  end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one arithmetic unit between two requesters, one operation in flight at a time,
// with a timeout that answers with an error and pulses au_rst when the unit goes silent.
module alu_arbiter
  import alu_pkg::*;
#(
  parameter int TIMEOUT = 8
) (
  input  logic         clk,
  input  logic         rst,
  alu_arbiter_if.slave bus,
  output arb_state_t   dbg_state
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);

  arb_state_t          state_q, state_d;
  logic                last_q, last_d;
  logic                gnt_q, gnt_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d, cnt_inc;
  logic [NUM_REQ-1:0]  rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0]   rsp_data_q, rsp_data_d;
  logic                rsp_err_q, rsp_err_d;
  logic                au_act_q, au_act_d;
  logic                au_rst_q, au_rst_d;
  opcode_t             op_q, op_d;
  logic [1:0]          movi_q, movi_d;
  logic [DATA_W-1:0]   a_q, a_d, b_q, b_d, mem_q, mem_d, imm_q, imm_d;
  logic [NUM_REQ-1:0]  req_ready_c;
  logic                gnt_valid, gnt_idx;

  rr_arbiter2 u_rr (
    .req       (bus.req_valid),
    .last      (last_q),
    .gnt_valid (gnt_valid),
    .gnt_idx   (gnt_idx)
  );

  assign cnt_inc = cnt_q + 1'b1;

  always_comb begin
    state_d     = state_q;
    last_d      = last_q;
    gnt_d       = gnt_q;
    cnt_d       = cnt_q;
    rsp_valid_d = rsp_valid_q;
    rsp_data_d  = rsp_data_q;
    rsp_err_d   = rsp_err_q;
    au_act_d    = 1'b0;
    au_rst_d    = 1'b0;
    op_d        = op_q;
    movi_d      = movi_q;
    a_d         = a_q;
    b_d         = b_q;
    mem_d       = mem_q;
    imm_d       = imm_q;
    req_ready_c = '0;
    case (state_q)
      ST_IDLE: begin
        if (gnt_valid) begin
          req_ready_c = onehot_req(gnt_idx);
          gnt_d       = gnt_idx;
          last_d      = gnt_idx;
          op_d        = opcode_t'(bus.req_op_code[gnt_idx]);
          movi_d      = bus.req_movi[gnt_idx];
          a_d         = bus.req_reg_a[gnt_idx];
          b_d         = bus.req_reg_b[gnt_idx];
          mem_d       = bus.req_mem[gnt_idx];
          imm_d       = bus.req_imm[gnt_idx];
          au_act_d    = 1'b1;
          state_d     = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        cnt_d   = '0;
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (bus.au_data_valid) begin
          rsp_data_d  = bus.au_data;
          rsp_err_d   = 1'b0;
          rsp_valid_d = onehot_req(gnt_q);
          state_d     = ST_RESP;
        end else if (cnt_inc == CNT_W'(TIMEOUT)) begin
          // Unit went silent: answer with an error and reset it for the next request.
          rsp_data_d  = '0;
          rsp_err_d   = 1'b1;
          rsp_valid_d = onehot_req(gnt_q);
          au_rst_d    = 1'b1;
          state_d     = ST_RESP;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      ST_RESP: begin
        if (bus.rsp_ready[gnt_q]) begin
          rsp_valid_d = '0;
          state_d     = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      last_q      <= 1'b1;
      gnt_q       <= 1'b0;
      cnt_q       <= '0;
      rsp_valid_q <= '0;
      rsp_data_q  <= '0;
      rsp_err_q   <= 1'b0;
      au_act_q    <= 1'b0;
      au_rst_q    <= 1'b1;
      op_q        <= ADD;
      movi_q      <= '0;
      a_q         <= '0;
      b_q         <= '0;
      mem_q       <= '0;
      imm_q       <= '0;
    end else begin
      state_q     <= state_d;
      last_q      <= last_d;
      gnt_q       <= gnt_d;
      cnt_q       <= cnt_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      rsp_err_q   <= rsp_err_d;
      au_act_q    <= au_act_d;
      au_rst_q    <= au_rst_d;
      op_q        <= op_d;
      movi_q      <= movi_d;
      a_q         <= a_d;
      b_q         <= b_d;
      mem_q       <= mem_d;
      imm_q       <= imm_d;
    end
  end

  // The grant is combinational, so it is masked while reset is asserted.
  assign bus.req_ready  = rst ? '0 : req_ready_c;
  assign bus.rsp_valid  = rsp_valid_q;
  assign bus.rsp_data   = rsp_data_q;
  assign bus.rsp_err    = rsp_err_q;
  assign bus.au_act     = au_act_q;
  assign bus.au_rst     = au_rst_q;
  assign bus.au_op_code = op_q;
  assign bus.au_movi    = movi_q;
  assign bus.au_reg_a   = a_q;
  assign bus.au_reg_b   = b_q;
  assign bus.au_mem     = mem_q;
  assign bus.au_imm     = imm_q;
  assign dbg_state      = state_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter with a behavioural arithmetic unit and an expected-response queue.
module tb_alu_arbiter;
  import alu_pkg::*;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  arb_state_t dbg_state;
  int         checks = 0;
  int         errors = 0;
  logic [32:0] exp_q[$];

  alu_arbiter_if bus ();

  alu_arbiter #(.TIMEOUT(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog expired got running exp finished");
    $fatal(1, "watchdog");
  end

  // ---------------- arithmetic unit model ----------------
  logic        au_en = 1'b1;
  logic        au_stray = 1'b0;
  logic [2:0]  au_cnt = '0;
  logic [31:0] au_b_sel, au_result;

  always_comb begin
    case (bus.au_movi)
      MOVI_MEM: au_b_sel = bus.au_mem;
      MOVI_IMM: au_b_sel = bus.au_imm;
      default:  au_b_sel = bus.au_reg_b;
    endcase
    case (bus.au_op_code)
      2'd0:    au_result = bus.au_reg_a + au_b_sel;
      2'd1:    au_result = bus.au_reg_a - au_b_sel;
      2'd2:    au_result = bus.au_reg_a * au_b_sel;
      default: au_result = (au_b_sel == 32'd0) ? 32'd0 : bus.au_reg_a / au_b_sel;
    endcase
  end

  always @(posedge clk) begin
    if (bus.au_rst)                     au_cnt <= '0;
    else if (bus.au_act)                au_cnt <= (bus.au_op_code == 2'd2) ? 3'd4 : 3'd1;
    else if (au_cnt != 3'd0)            au_cnt <= au_cnt - 3'd1;
  end

  assign bus.au_data       = au_result;
  assign bus.au_data_valid = (au_en && au_cnt == 3'd1) || au_stray;

  // ---------------- check / driver tasks ----------------
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s got %0h exp %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  function automatic logic [1:0] exp_onehot(input logic r);
    logic [1:0] v;
    v = 2'b00;
    v[r] = 1'b1;
    return v;
  endfunction

  task automatic drive_req(input logic r, input logic [1:0] op, input logic [1:0] movi,
                           input logic [31:0] a, input logic [31:0] b,
                           input logic [31:0] mem, input logic [31:0] imm);
    bus.req_op_code[r] = op;
    bus.req_movi[r]    = movi;
    bus.req_reg_a[r]   = a;
    bus.req_reg_b[r]   = b;
    bus.req_mem[r]     = mem;
    bus.req_imm[r]     = imm;
  endtask

  task automatic transact(input logic r, input logic [1:0] op, input logic [1:0] movi,
                          input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] mem, input logic [31:0] imm,
                          input int exp_lat, input logic [31:0] exp_data,
                          input logic exp_err, input int hold);
    int         cyc;
    int         waitc;
    logic       o;
    logic [32:0] exp;
    o = ~r;
    drive_req(r, op, movi, a, b, mem, imm);
    bus.req_valid[r] = 1'b1;
    exp_q.push_back({exp_err, exp_data});
    #1;
    waitc = 0;
    while (!bus.req_ready[r] && waitc < 20) begin
      tick();
      #1;
      waitc++;
    end
    chk("accept_wait", 32'(waitc), 32'd0);
    chk("req_ready_grant", 32'(bus.req_ready), 32'(exp_onehot(r)));
    tick();
    bus.req_valid[r] = 1'b0;
    cyc = 1;
    chk("au_act_issue", 32'(bus.au_act), 32'd1);
    chk("state_issue", 32'(dbg_state), 32'(ST_ISSUE));
    while (bus.rsp_valid == 2'b00 && cyc < 40) begin
      chk("busy_ready", 32'(bus.req_ready), 32'd0);
      chk("au_a_stable", bus.au_reg_a, a);
      chk("au_op_stable", 32'(bus.au_op_code), 32'(op));
      chk("au_b_stable", bus.au_reg_b, b);
      tick();
      cyc++;
      if (cyc == 2) chk("au_act_pulse", 32'(bus.au_act), 32'd0);
    end
    chk("rsp_latency", 32'(cyc), 32'(exp_lat));
    chk("rsp_valid", 32'(bus.rsp_valid), 32'(exp_onehot(r)));
    exp = exp_q.pop_front();
    chk("rsp_data", bus.rsp_data, exp[31:0]);
    chk("rsp_err", 32'(bus.rsp_err), 32'(exp[32]));
    chk("au_rst_pulse", 32'(bus.au_rst), 32'(exp[32]));
    for (int h = 0; h < hold; h++) begin
      bus.req_valid[o] = 1'b1;
      bus.rsp_ready[o] = 1'b1;
      tick();
      #1;
      chk("hold_rsp_valid", 32'(bus.rsp_valid), 32'(exp_onehot(r)));
      chk("hold_rsp_data", bus.rsp_data, exp[31:0]);
      chk("hold_req_ready", 32'(bus.req_ready), 32'd0);
      chk("hold_au_rst", 32'(bus.au_rst), 32'd0);
    end
    bus.req_valid[o] = 1'b0;
    bus.rsp_ready    = exp_onehot(r);
    tick();
    bus.rsp_ready = 2'b00;
    chk("rsp_valid_clr", 32'(bus.rsp_valid), 32'd0);
    chk("state_idle", 32'(dbg_state), 32'(ST_IDLE));
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    logic g;
    int   cyc;
    logic [32:0] exp;

    bus.req_valid   = '0;
    bus.rsp_ready   = '0;
    bus.req_op_code = '0;
    bus.req_movi    = '0;
    bus.req_reg_a   = '0;
    bus.req_reg_b   = '0;
    bus.req_mem     = '0;
    bus.req_imm     = '0;

    // Reset values, and no grant while reset is held.
    tick();
    tick();
    bus.req_valid = 2'b01;
    #1;
    chk("rst_req_ready", 32'(bus.req_ready), 32'd0);
    bus.req_valid = 2'b00;
    chk("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    chk("rst_rsp_data", bus.rsp_data, 32'd0);
    chk("rst_rsp_err", 32'(bus.rsp_err), 32'd0);
    chk("rst_au_act", 32'(bus.au_act), 32'd0);
    chk("rst_au_a", bus.au_reg_a, 32'd0);
    chk("rst_au_rst", 32'(bus.au_rst), 32'd1);
    chk("rst_state", 32'(dbg_state), 32'(ST_IDLE));
    rst = 1'b0;
    tick();
    chk("au_rst_release", 32'(bus.au_rst), 32'd0);

    // ADD 5 + IMM 7 from requester 0.
    transact(1'b0, ADD, MOVI_IMM, 32'd5, 32'd0, 32'd0, 32'd7, 3, 32'd12, 1'b0, 0);
    // MUL 6 * 7 from requester 1.
    transact(1'b1, MUL, MOVI_REG_B, 32'd6, 32'd7, 32'd0, 32'd0, 6, 32'd42, 1'b0, 0);

    // Both requesters continuously valid: grants alternate 0,1,0,1.
    drive_req(1'b0, SUB, MOVI_REG_B, 32'd10, 32'd3, 32'd0, 32'd0);
    drive_req(1'b1, SUB, MOVI_REG_B, 32'd10, 32'd3, 32'd0, 32'd0);
    bus.req_valid = 2'b11;
    for (int i = 0; i < 4; i++) begin
      g = i[0];
      exp_q.push_back({1'b0, 32'd7});
      #1;
      chk("rr_grant", 32'(bus.req_ready), 32'(exp_onehot(g)));
      tick();
      cyc = 1;
      while (bus.rsp_valid == 2'b00 && cyc < 20) begin
        chk("rr_busy_ready", 32'(bus.req_ready), 32'd0);
        tick();
        cyc++;
      end
      chk("rr_latency", 32'(cyc), 32'd3);
      chk("rr_rsp_valid", 32'(bus.rsp_valid), 32'(exp_onehot(g)));
      exp = exp_q.pop_front();
      chk("rr_rsp_data", bus.rsp_data, exp[31:0]);
      bus.rsp_ready = exp_onehot(g);
      tick();
      bus.rsp_ready = 2'b00;
    end
    bus.req_valid = 2'b00;

    // Silent arithmetic unit: timeout error after 8 WAIT cycles, one-cycle au_rst.
    au_en = 1'b0;
    transact(1'b0, ADD, MOVI_REG_B, 32'd1, 32'd2, 32'd0, 32'd0, 10, 32'd0, 1'b1, 1);
    au_en = 1'b1;

    // DIV 9/0 with the response held for 5 cycles; the other requester pokes meanwhile.
    transact(1'b1, DIV, MOVI_REG_B, 32'd9, 32'd0, 32'd0, 32'd0, 3, 32'd0, 1'b0, 5);

    // Reset in the middle of a MUL.
    drive_req(1'b1, MUL, MOVI_REG_B, 32'd6, 32'd7, 32'd0, 32'd0);
    bus.req_valid[1] = 1'b1;
    #1;
    chk("mul_grant", 32'(bus.req_ready), 32'h2);
    tick();
    bus.req_valid[1] = 1'b0;
    tick();
    tick();
    chk("mul_state_wait", 32'(dbg_state), 32'(ST_WAIT));
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    chk("mid_rst_state", 32'(dbg_state), 32'(ST_IDLE));
    chk("mid_rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    chk("mid_rst_rsp_data", bus.rsp_data, 32'd0);
    chk("mid_rst_au_act", 32'(bus.au_act), 32'd0);
    chk("mid_rst_au_a", bus.au_reg_a, 32'd0);
    chk("mid_rst_au_op", 32'(bus.au_op_code), 32'd0);
    chk("mid_rst_req_ready", 32'(bus.req_ready), 32'd0);
    chk("mid_rst_au_rst", 32'(bus.au_rst), 32'd1);
    au_stray = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("stray_state", 32'(dbg_state), 32'(ST_IDLE));
      chk("stray_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    end
    au_stray = 1'b0;
    // After reset requester 0 has priority on a tie.
    bus.req_valid = 2'b11;
    #1;
    chk("post_rst_tie_grant", 32'(bus.req_ready), 32'h1);
    bus.req_valid = 2'b00;

    // Normal service resumes; single requester served back-to-back.
    transact(1'b0, ADD, MOVI_REG_B, 32'd20, 32'd22, 32'd0, 32'd0, 3, 32'd42, 1'b0, 0);
    transact(1'b0, SUB, MOVI_MEM, 32'd100, 32'd0, 32'd1, 32'd0, 3, 32'd99, 1'b0, 0);
    transact(1'b1, DIV, MOVI_IMM, 32'd100, 32'd0, 32'd0, 32'd7, 3, 32'd14, 1'b0, 0);
    transact(1'b1, MUL, MOVI_MEM, 32'h10000, 32'd0, 32'h10001, 32'd0, 6, 32'h10000, 1'b0, 0);

    chk("exp_q_empty", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 Parameter TIMEOUT, default 8: max cycles in WAIT without AU_DATA_VALID before error response.
REQ-002 CLK  in  1  single clock; all state changes on rising edge.
REQ-003 RST  in  1  reset, synchronous, active-high.
REQ-004 REQ_VALID  in  [1:0]  per-requester request valid.
REQ-005 REQ_READY  out  [1:0]  per-requester accept; a request transfers when VALID&READY.
REQ-006 REQ_OP_CODE / REQ_MOVI  in  [1:0][1:0]  per-requester operator (ADD/SUB/MUL/DIV) and operand-B selector.
REQ-007 REQ_REG_A / REQ_REG_B / REQ_MEM / REQ_IMM  in  [1:0][31:0]  per-requester operands.
REQ-008 RSP_VALID  out  [1:0]  per-requester response valid; RSP_READY  in  [1:0]  response accept.
REQ-009 RSP_DATA  out  32  result; RSP_ERR  out  1  timeout flag; both shared, meaningful only with RSP_VALID.
REQ-010 AU_ACT, AU_OP_CODE[1:0], AU_MOVI[1:0], AU_REG_A/B, AU_MEM, AU_IMM[31:0]  out  drive to arithmetic unit.
REQ-011 AU_DATA  in  32, AU_DATA_VALID  in  1  result from arithmetic unit; AU_RST  out  1  unit reset.

Function
REQ-012 FSM states IDLE, ISSUE, WAIT, RESP; exactly one request in flight.
REQ-013 IDLE: if any REQ_VALID, grant g by round-robin (priority to requester not last granted; after reset, requester 0 first); REQ_READY[g]=1 combinationally that cycle, others 0; latch g's fields into operand registers; -> ISSUE.
REQ-014 REQ_READY SHALL be 0 in all states other than IDLE.
REQ-015 ISSUE: AU_ACT=1 for exactly this cycle; clear timeout counter; -> WAIT.
REQ-016 AU_OP_CODE/MOVI/operands SHALL be the latched values, stable from ISSUE through the cycle AU_DATA_VALID is sampled (MUL samples operands at completion).
REQ-017 WAIT: on AU_DATA_VALID capture AU_DATA into RSP_DATA, RSP_ERR=0, -> RESP; AU_DATA_VALID in any other state is ignored.
REQ-018 WAIT: counter increments each cycle without AU_DATA_VALID; when counter reaches TIMEOUT: RSP_DATA=0, RSP_ERR=1, AU_RST pulsed high one cycle, -> RESP.
REQ-019 RESP: RSP_VALID[g]=1, others 0, RSP_DATA/RSP_ERR stable; on RSP_READY[g] -> IDLE; RSP_READY of non-granted requester ignored.
REQ-020 Latency (accept cycle = 0): ADD/SUB/DIV RSP_VALID at cycle 3; MUL at cycle 6; new accept no earlier than cycle after RSP handshake.
REQ-021 Round-robin pointer updates only on accept; single requester repeatedly valid is served back-to-back.
REQ-022 Both valid in IDLE: only g accepted; loser's REQ_VALID and fields SHALL be held by requester (not latched).

Reset
REQ-023 RST in any state (including mid-MUL in WAIT) -> IDLE next edge; pending request dropped, no response.
REQ-024 Reset values: REQ_READY=0, RSP_VALID=0, RSP_DATA=0, RSP_ERR=0, AU_ACT=0, AU_* operands/codes=0, last-grant=1, counter=0.
REQ-025 AU_RST = 1 while RST is 1 and for the timeout pulse; registered, glitch-free.

Structure
REQ-026 Package alu_pkg: opcode_t (ADD=0, SUB=1, MUL=2, DIV=3), movi encoding constants, arb_state_t, NUM_REQ=2.
REQ-027 Sub-module rr_arbiter2: 2-way round-robin grant from request vector and last-grant register; FSM and datapath stay in alu_arbiter.

Verification
REQ-028 Req0 ADD, A=5, MOVI=2, IMM=7 -> AU_ACT at cycle 1, RSP_VALID[0] at cycle 3, RSP_DATA=12, RSP_ERR=0.
REQ-029 Req1 MUL A=6, B=7 (MOVI=0) -> operands stable through WAIT, RSP_VALID[1] at cycle 6, RSP_DATA=42.
REQ-030 Both valid continuously, SUB 10-3 on each -> grants alternate 0,1,0,1; each RSP_DATA=7; never both RSP_VALID.
REQ-031 AU model never asserts AU_DATA_VALID, TIMEOUT=8 -> RSP_ERR=1, RSP_DATA=0, one-cycle AU_RST pulse, FSM back to IDLE after RSP_READY.
REQ-032 RST asserted in WAIT during MUL -> next cycle all outputs at reset values; later AU_DATA_VALID ignored; next request served normally.
REQ-033 RSP_READY held low 5 cycles, DIV 9/0 -> RSP_VALID and RSP_DATA=0 stable all 5 cycles; no REQ_READY until handshake.
